// File: rtl/rr_mux_4x1.sv
// rr_mux_4x1 -- four-channel round-robin multiplexer with valid/ready handshake.
//
// The block gathers words from four source channels onto one registered output
// stream. Each output word carries the index of the channel it came from on
// {s1,s0}, so a downstream 1-to-4 demux can route it back.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   a0..a3    channel data words (DATA_W bits each)
//   in_valid  bit k: channel k offers a word on ak
//   in_ready  bit k: channel k's word is taken this cycle (one-hot or zero)
//   y         registered output word
//   y_valid   y, s1, s0 hold a word
//   y_ready   downstream takes the word this cycle
//   s1, s0    source channel index of the word on y (MSB, LSB)

module rr_mux_4x1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              s1,
  output logic              s0
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_y;
  logic              r_yValid;

  logic              w_slotFree;
  logic              w_grant;
  logic [1:0]        w_grantIdx;
  logic [DATA_W-1:0] w_grantData;

  // The output slot can take a new word when it is empty, or when the word it
  // holds leaves this very cycle (pop and push on the same edge).
  assign w_slotFree = (r_state == EMPTY) || y_ready;

  // Round-robin scan starting at r_ptr; the 2-bit index wraps naturally mod 4.
  // Nothing is granted while reset is held, so no source believes its word
  // was taken while the block is being cleared.
  always_comb begin
    logic [1:0] w_idx;
    w_grant    = 1'b0;
    w_grantIdx = 2'd0;
    w_idx      = 2'd0;
    if (w_slotFree && !rst) begin
      for (int i = 3; i >= 0; i--) begin
        w_idx = r_ptr + 2'(i);
        if (in_valid[w_idx]) begin
          w_grant    = 1'b1;
          w_grantIdx = w_idx;
        end
      end
    end
  end

  // Iterating from the far end backwards means the last hit written is the
  // closest channel to r_ptr, which is the round-robin winner.
  assign in_ready = w_grant ? (4'b0001 << w_grantIdx) : 4'b0000;

  // Select the winning channel's word for loading into the output register.
  always_comb begin
    w_grantData = a0;
    case (w_grantIdx)
      2'd1:    w_grantData = a1;
      2'd2:    w_grantData = a2;
      2'd3:    w_grantData = a3;
      default: w_grantData = a0;
    endcase
  end

  // Output register and slot FSM. A grant always loads the slot (covering the
  // back-to-back case); a pop without a grant just marks the slot empty and
  // leaves the old data visible on y/s1/s0. The pointer only moves on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_ptr    <= 2'd0;
      r_sel    <= 2'd0;
      r_y      <= '0;
      r_yValid <= 1'b0;
    end else if (w_grant) begin
      r_state  <= FULL;
      r_ptr    <= w_grantIdx + 2'd1;
      r_sel    <= w_grantIdx;
      r_y      <= w_grantData;
      r_yValid <= 1'b1;
    end else if (r_state == FULL && y_ready) begin
      r_state  <= EMPTY;
      r_yValid <= 1'b0;
    end
  end

  assign y       = r_y;
  assign y_valid = r_yValid;
  assign s1      = r_sel[1];
  assign s0      = r_sel[0];

endmodule

// File: tb/tb_rr_mux_4x1.sv
// tb_rr_mux_4x1 -- self-checking bench for rr_mux_4x1.
//
// A behavioural model (a held-word record plus an integer round-robin pointer)
// predicts in_ready before each edge and y/y_valid/{s1,s0} after it. Directed
// scenarios cover reset, single channel, fairness, backpressure, wrap-around and
// drain; a randomized run then exercises the handshake rules at large.

module tb_rr_mux_4x1;

  logic       clk;
  logic       rst;
  logic [7:0] aIn [4];
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;
  logic       s1;
  logic       s0;

  int vectors;
  int miscompares;

  // Reference model state
  bit         mValid;
  logic [7:0] mY;
  logic [1:0] mSel;
  int         mPtr;
  int         lastGrant;

  rr_mux_4x1 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a0       (aIn[0]),
    .a1       (aIn[1]),
    .a2       (aIn[2]),
    .a3       (aIn[3]),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .s1       (s1),
    .s0       (s0)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Which channel should win right now, or -1 for no grant.
  function automatic int expGrant();
    if (rst) return -1;
    if (mValid && !y_ready) return -1;
    for (int i = 0; i < 4; i++) begin
      if (in_valid[(mPtr + i) % 4]) return (mPtr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] expReady();
    int g;
    g = expGrant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  function automatic logic [10:0] expOut();
    return {mValid, mSel, mY};
  endfunction

  function automatic logic [10:0] obsOut();
    return {y_valid, s1, s0, y};
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mY     = 8'h00;
    mSel   = 2'd0;
    mPtr   = 0;
  endtask

  // Advance one clock edge and update the model with the pre-edge decision.
  task automatic tick();
    int g;
    g = expGrant();
    @(posedge clk);
    if (g >= 0) begin
      mY     = aIn[g];
      mSel   = 2'(g);
      mValid = 1'b1;
      mPtr   = (g + 1) % 4;
    end else if (mValid && y_ready) begin
      mValid = 1'b0;
    end
    lastGrant = g;
    #1;
  endtask

  // Drive all channel inputs and the downstream ready in one go.
  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] d0,
                               input logic [7:0] d1, input logic [7:0] d2,
                               input logic [7:0] d3, input logic rdy);
    in_valid = v;
    aIn[0]   = d0;
    aIn[1]   = d1;
    aIn[2]   = d2;
    aIn[3]   = d3;
    y_ready  = rdy;
    #1;
  endtask

  // Synchronous-looking reset sequence, released away from the clock edge.
  task automatic doReset();
    rst = 1'b1;
    modelReset();
    applyStimulus(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    modelReset();
    applyStimulus(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got=%b exp=0000", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obsOut() !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=%h exp=000", obsOut());
    end
    #2;
    rst = 1'b0;
    #1;
    tick();
    vectors++;
    if (obsOut() !== {1'b1, 2'd0, 8'h11}) begin
      miscompares++;
      $display("[TB] FAIL reset_first_word got=%h exp=%h", obsOut(), {1'b1, 2'd0, 8'h11});
    end
    // Asynchronous reset between edges while a word is held.
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    vectors++;
    if (obsOut() !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_clear got=%h exp=000", obsOut());
    end
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_async_in_ready got=%b exp=0000", in_ready);
    end
    #1;
    rst = 1'b0;
    #1;
    // Pointer must be back at 0 after reset.
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL reset_ptr_zero got=%b exp=0001", in_ready);
    end
  endtask

  task automatic test_single_and_wrap();
    doReset();
    applyStimulus(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1);
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL single_in_ready got=%b exp=0100", in_ready);
    end
    tick();
    vectors++;
    if (obsOut() !== {1'b1, 2'b10, 8'hA5}) begin
      miscompares++;
      $display("[TB] FAIL single_out got=%h exp=%h", obsOut(), {1'b1, 2'b10, 8'hA5});
    end
    // Pointer now 3: channel 0 must beat channel 1.
    applyStimulus(4'b0011, 8'h5C, 8'h6D, 8'h00, 8'h00, 1'b1);
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL wrap_in_ready got=%b exp=0001", in_ready);
    end
    tick();
    vectors++;
    if (obsOut() !== {1'b1, 2'b00, 8'h5C}) begin
      miscompares++;
      $display("[TB] FAIL wrap_out got=%h exp=%h", obsOut(), {1'b1, 2'b00, 8'h5C});
    end
    // Pointer now 1: channel 1 wins.
    vectors++;
    if (in_ready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL wrap_ptr_one got=%b exp=0010", in_ready);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [7:0] vals [4];
    vals[0] = 8'h10; vals[1] = 8'h21; vals[2] = 8'h32; vals[3] = 8'h43;
    doReset();
    applyStimulus(4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obsOut() !== {1'b1, 2'(i % 4), vals[i % 4]}) begin
        miscompares++;
        $display("[TB] FAIL fairness_%0d got=%h exp=%h", i, obsOut(), {1'b1, 2'(i % 4), vals[i % 4]});
      end
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(4'b1111, 8'h10, 8'h21, 8'h32, 8'h43, 1'b1);
    tick();
    tick();
    y_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL backpressure_in_ready_%0d got=%b exp=0000", i, in_ready);
      end
      tick();
      vectors++;
      if (obsOut() !== {1'b1, 2'd1, 8'h21}) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold_%0d got=%h exp=%h", i, obsOut(), {1'b1, 2'd1, 8'h21});
      end
    end
    y_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release got=%b exp=0100", in_ready);
    end
    tick();
    vectors++;
    if (obsOut() !== {1'b1, 2'd2, 8'h32}) begin
      miscompares++;
      $display("[TB] FAIL backpressure_push got=%h exp=%h", obsOut(), {1'b1, 2'd2, 8'h32});
    end
  endtask

  task automatic test_drain();
    applyStimulus(4'b0000, 8'h10, 8'h21, 8'h32, 8'h43, 1'b1);
    tick();
    vectors++;
    if (obsOut() !== {1'b0, 2'd2, 8'h32}) begin
      miscompares++;
      $display("[TB] FAIL drain got=%h exp=%h", obsOut(), {1'b0, 2'd2, 8'h32});
    end
    tick();
    vectors++;
    if (obsOut() !== {1'b0, 2'd2, 8'h32}) begin
      miscompares++;
      $display("[TB] FAIL drain_idle got=%h exp=%h", obsOut(), {1'b0, 2'd2, 8'h32});
    end
  endtask

  task automatic test_random();
    doReset();
    for (int n = 0; n < 400; n++) begin
      // Sources keep offered words stable until taken; idle ones may start offering.
      for (int k = 0; k < 4; k++) begin
        if (lastGrant == k) in_valid[k] = 1'b0;
        if (!in_valid[k] && ($urandom_range(0, 1) == 1)) begin
          in_valid[k] = 1'b1;
          aIn[k]      = 8'($urandom);
        end
      end
      y_ready = ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (in_ready !== expReady()) begin
        miscompares++;
        $display("[TB] FAIL random_in_ready_%0d got=%b exp=%b", n, in_ready, expReady());
      end
      tick();
      vectors++;
      if (obsOut() !== expOut()) begin
        miscompares++;
        $display("[TB] FAIL random_out_%0d got=%h exp=%h", n, obsOut(), expOut());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    lastGrant   = -1;
    rst         = 1'b1;
    in_valid    = 4'b0000;
    y_ready     = 1'b0;
    for (int k = 0; k < 4; k++) aIn[k] = 8'h00;
    modelReset();

    test_reset();
    test_single_and_wrap();
    test_fairness();
    test_back_to_back();
    test_drain();
    lastGrant = -1;
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_mux_4x1.md
Name: rr_mux_4x1

Overview:
Four-channel round-robin multiplexer with a valid/ready handshake. It collects words from four source channels and sends them on one registered output stream. Each output word carries its source index on s1/s0, so a downstream demux_1x4 can route it back. The block sits upstream of the 1-to-4 demux, at the gathering end of the same shared-lane path.

Parameters:
DATA_W, 8, width of each data word

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
a0  input  DATA_W  channel 0 data
a1  input  DATA_W  channel 1 data
a2  input  DATA_W  channel 2 data
a3  input  DATA_W  channel 3 data
in_valid  input  4  bit k: channel k offers a word on ak
in_ready  output  4  bit k: channel k's word is accepted this cycle; at most one bit set
y  output  DATA_W  registered output data
y_valid  output  1  y, s1, s0 hold a word
y_ready  input  1  downstream accepts the word this cycle
s1  output  1  source channel index, MSB
s0  output  1  source channel index, LSB

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset state while rst=1, and on release:
  - y=0, y_valid=0, s1=0, s0=0.
  - Round-robin pointer ptr=0.
  - FSM in EMPTY.
  - in_ready=0 for the whole time rst=1.
- FSM states:
  - EMPTY: output register holds nothing; y_valid=0.
  - FULL: output register holds a word; y_valid=1.
- Slot free condition: (state==EMPTY) or (state==FULL and y_ready=1).
- Grant rule, combinational, evaluated only when the slot is free:
  - Scan channels ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first k with in_valid[k]=1 wins.
  - in_ready[k]=1 for the winner only; all other bits 0.
  - No winner, or slot not free: in_ready=0.
- On the clk edge with a grant to channel k:
  - y <= ak, {s1,s0} <= k, y_valid <= 1, ptr <= (k+1) mod 4.
  - Next state is FULL.
- On the clk edge with FULL, y_ready=1 and no grant:
  - y_valid <= 0, next state is EMPTY.
  - y, s1, s0 keep their last values.
- While FULL and y_ready=0: y, s1, s0, y_valid are held stable; no grants.
- Latency: 1 cycle from acceptance (in_valid[k] & in_ready[k]) to y_valid=1.
- Throughput: 1 word per cycle while y_ready stays high. Back-to-back pop and push occur on the same edge.
- ptr changes only on a grant. Idle cycles do not move it.
- Fairness: with all four channels continuously valid, grant order is 0,1,2,3,0,... Each channel waits at most 3 grants.
- in_ready depends combinationally on in_valid, state, ptr and y_ready. No combinational path exists from any ak to y.
- A source must hold ak and in_valid[k] stable until accepted. The block never drops an accepted word, except by reset.
- Reset mid-operation: any held word is discarded, y_valid drops immediately (asynchronous), ptr returns to 0.
- in_valid=0000 throughout: the block stays in EMPTY with no output activity.

Test Plan:
- Reset: assert rst asynchronously between edges with y_valid=1 -> y_valid, y, s1, s0 go to 0 before the next edge; in_ready=0000 while rst=1.
- Single channel: rst released, in_valid=0100, a2=8'hA5, y_ready=1 -> in_ready=0100 that cycle; next cycle y=8'hA5, y_valid=1, {s1,s0}=2'b10; ptr becomes 3.
- Fairness: all in_valid=1111, a0..a3=8'h10,8'h21,8'h32,8'h43, y_ready=1 from reset -> y sequence 10,21,32,43,10 on consecutive cycles; {s1,s0}=0,1,2,3,0.
- Backpressure: y_ready=0 with y_valid=1 holding 8'h21 for 5 cycles while in_valid=1111 -> y, s1, s0 stable and in_ready=0000 throughout; when y_ready=1 the pop and the next grant (channel 2) happen on the same edge.
- Wrap-around: ptr=3 and in_valid=0011 -> channel 0 granted, not channel 1; ptr becomes 1.
- Drain: one word held, then in_valid=0000 with y_ready=1 -> y_valid=0 next cycle, state EMPTY, y unchanged.
